// File: rtl/delay_sensor_readout.sv
`default_nettype none
// ============================================================================
//  Module      : delay_sensor_readout
//  Description : Launch/capture controller for an inverter delay-chain sensor;
//                averages 2^N_AVG_LOG2 thermometer-decoded depths per result.
//  Revision    : 1.0  initial release
// ============================================================================
module delay_sensor_readout #(
    parameter int N_TAPS      = 16,
    parameter int N_AVG_LOG2  = 2,
    parameter int CAPTURE_DLY = 1,
    parameter int SETTLE_CYC  = 2,
    parameter int W           = $clog2(N_TAPS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              launch,
    input  logic [N_TAPS-1:0] taps,
    output logic              busy,
    output logic [W-1:0]      result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              bubble_err
);

    localparam int AW = W + N_AVG_LOG2;
    localparam int SW = N_AVG_LOG2 + 1;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_launch  = 3'd1;
    localparam logic [2:0] c_st_wait    = 3'd2;
    localparam logic [2:0] c_st_capture = 3'd3;
    localparam logic [2:0] c_st_eval    = 3'd4;
    localparam logic [2:0] c_st_settle  = 3'd5;
    localparam logic [2:0] c_st_done    = 3'd6;

    localparam logic [3:0]    c_cap_load    = 4'(CAPTURE_DLY - 1);
    localparam logic [3:0]    c_settle_load = 4'(SETTLE_CYC - 1);
    localparam logic [SW-1:0] c_samp_last   = SW'((1 << N_AVG_LOG2) - 1);
    localparam logic [SW-1:0] c_samp_one    = SW'(1);
    localparam logic [W-1:0]  c_depth_one   = W'(1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic              r_launch;
    logic [3:0]        r_wcnt;
    logic [SW-1:0]     r_samp;
    logic [AW-1:0]     r_acc;
    logic [N_TAPS-1:0] r_cap;
    logic              r_lvl;
    logic [W-1:0]      r_result;
    logic              r_result_valid;
    logic              r_bubble;

    logic [W-1:0]      w_depth;
    logic              w_bubble;
    logic              w_run;
    logic [AW-1:0]     w_acc_sum;

    // Leading run of bits matching the launch level; any later match is a bubble.
    always_comb begin
        w_depth  = '0;
        w_bubble = 1'b0;
        w_run    = 1'b1;
        for (int i = 0; i < N_TAPS; i++) begin
            if (r_cap[i] == r_lvl) begin
                if (w_run) begin
                    w_depth = w_depth + c_depth_one;
                end else begin
                    w_bubble = 1'b1;
                end
            end else begin
                w_run = 1'b0;
            end
        end
    end

    assign w_acc_sum = r_acc + AW'(w_depth);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:    if (start) w_next = c_st_launch;
            c_st_launch:  w_next = c_st_wait;
            c_st_wait:    if (r_wcnt == 4'd0) w_next = c_st_capture;
            c_st_capture: w_next = c_st_eval;
            c_st_eval:    w_next = (r_samp == c_samp_last) ? c_st_done : c_st_settle;
            c_st_settle:  if (r_wcnt == 4'd0) w_next = c_st_launch;
            c_st_done:    if (r_result_valid && result_ready) w_next = c_st_idle;
            default:      w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_launch       <= 1'b0;
            r_wcnt         <= '0;
            r_samp         <= '0;
            r_acc          <= '0;
            r_cap          <= '0;
            r_lvl          <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_bubble       <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_acc  <= '0;
                    r_samp <= '0;
                    if (start) r_bubble <= 1'b0;
                end
                c_st_launch: begin
                    r_launch <= ~r_launch;
                    r_wcnt   <= c_cap_load;
                end
                c_st_wait: begin
                    if (r_wcnt != 4'd0) r_wcnt <= r_wcnt - 4'd1;
                end
                c_st_capture: begin
                    r_cap <= taps;
                    r_lvl <= r_launch;
                end
                c_st_eval: begin
                    r_acc  <= w_acc_sum;
                    r_samp <= r_samp + c_samp_one;
                    r_wcnt <= c_settle_load;
                    if (w_bubble) r_bubble <= 1'b1;
                    if (r_samp == c_samp_last) begin
                        r_result       <= W'(w_acc_sum >> N_AVG_LOG2);
                        r_result_valid <= 1'b1;
                    end
                end
                c_st_settle: begin
                    if (r_wcnt != 4'd0) r_wcnt <= r_wcnt - 4'd1;
                end
                c_st_done: begin
                    if (result_ready) r_result_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign launch       = r_launch;
    assign busy         = (r_state != c_st_idle);
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign bubble_err   = r_bubble;

endmodule
`default_nettype wire
